// File: rtl/quant_pack_u8.sv
// quant_pack_u8: finish requantization to uint8, pack PACK_N lanes per word, buffer words in a show-ahead FIFO
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   valid_in  / in_ready  : input beat handshake (fx_in, index, z3, last_in)
//   fx_in     : signed 32-bit value before the rounding shift
//   index     : right-shift exponent (clamped to 31)
//   z3        : unsigned output zero point
//   last_in   : final byte of a tile, forces word emission
//   out_valid / out_ready : output word handshake
//   out_data  : packed bytes, lane 0 in bits [7:0]
//   out_keep  : per-lane valid bits
//   out_last  : word closes a tile
module quant_pack_u8 #(
  parameter int PACK_N     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  in_ready,
  input  logic [31:0]           fx_in,
  input  logic [7:0]            index,
  input  logic [7:0]            z3,
  input  logic                  last_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*PACK_N-1:0]   out_data,
  output logic [PACK_N-1:0]     out_keep,
  output logic                  out_last
);
  localparam int CW = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = 8 * PACK_N;
  localparam int EW = DW + PACK_N + 1;

  logic               r_s1_v, r_s1_last, r_s2_v, r_s2_last;
  logic [32:0]        r_s1_q;
  logic [7:0]         r_s1_z3, r_s2_u8;
  logic [CW-1:0]      r_cnt_b;
  logic [DW-1:0]      r_lanes;
  logic [PACK_N-1:0]  r_keep;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr, r_rd;
  logic [NW-1:0]      r_cnt;

  logic [4:0]         w_sh;
  logic [31:0]        w_mask, w_rem, w_thr;
  logic signed [31:0] w_shr;
  logic [32:0]        w_q;
  logic [33:0]        w_s;
  logic [7:0]         w_u8;
  logic [DW-1:0]      w_word;
  logic [PACK_N-1:0]  w_keep;
  logic [EW-1:0]      w_head;
  logic               w_acc, w_full, w_pop, w_commit, w_stall, w_push;

  // Stage 1: rounding right shift; ties round away from zero via the sign-biased threshold
  assign w_sh   = (index > 8'd31) ? 5'd31 : index[4:0];
  assign w_mask = ~(32'hFFFF_FFFF << w_sh);
  assign w_rem  = fx_in & w_mask;
  assign w_thr  = (w_mask >> 1) + {31'd0, fx_in[31]};
  assign w_shr  = $signed(fx_in) >>> w_sh;
  assign w_q    = {w_shr[31], w_shr} + {32'd0, (w_rem > w_thr)};

  // Stage 2: add zero point in 34 bits and saturate to uint8
  assign w_s  = {r_s1_q[32], r_s1_q} + {26'd0, r_s1_z3};
  assign w_u8 = w_s[33] ? 8'd0 : (|w_s[32:8]) ? 8'hFF : w_s[7:0];

  // Packer: merge the stage-2 byte into the partial word; a committed word goes straight into the FIFO
  assign w_word   = r_lanes | ({{(DW-8){1'b0}}, r_s2_u8} << {r_cnt_b, 3'b000});
  assign w_keep   = r_keep | ({{(PACK_N-1){1'b0}}, 1'b1} << r_cnt_b);
  assign w_commit = r_s2_v & ((r_cnt_b == CW'(PACK_N - 1)) | r_s2_last);

  assign w_acc    = valid_in & in_ready;
  assign w_full   = (r_cnt == NW'(FIFO_DEPTH));
  assign w_pop    = out_valid & out_ready;
  // A run of last-flagged beats can commit more words than the reserved slot holds;
  // freeze the pipeline rather than overflow (in_ready is already low whenever full)
  assign w_stall  = w_commit & w_full & ~w_pop;
  assign w_push   = w_commit & ~w_stall;

  assign in_ready  = (r_cnt < NW'(FIFO_DEPTH - 1));
  assign out_valid = (r_cnt != '0);
  assign w_head    = r_mem[r_rd];
  assign out_data  = out_valid ? w_head[DW-1:0] : '0;
  assign out_keep  = out_valid ? w_head[DW+PACK_N-1:DW] : '0;
  assign out_last  = out_valid & w_head[EW-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v    <= 1'b0;
      r_s1_q    <= '0;
      r_s1_z3   <= '0;
      r_s1_last <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_u8   <= '0;
      r_s2_last <= 1'b0;
      r_cnt_b   <= '0;
      r_lanes   <= '0;
      r_keep    <= '0;
    end else if (!w_stall) begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_q    <= w_q;
        r_s1_z3   <= z3;
        r_s1_last <= last_in;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_u8   <= w_u8;
        r_s2_last <= r_s1_last;
      end
      if (r_s2_v) begin
        r_cnt_b <= w_commit ? '0 : r_cnt_b + CW'(1);
        r_lanes <= w_commit ? '0 : w_word;
        r_keep  <= w_commit ? '0 : w_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop) r_rd <= (r_rd == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd + PW'(1);
      r_cnt <= r_cnt + NW'(w_push) - NW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_s2_last, w_keep, w_word};
  end
endmodule

// File: tb/tb_quant_pack_u8.sv
// tb_quant_pack_u8: randomized and directed check of quant_pack_u8 against an arithmetic reference model
module tb_quant_pack_u8;
  localparam int PN = 8;
  localparam int FD = 4;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, in_ready, last_in, out_valid, out_ready, out_last;
  logic [31:0] fx_in;
  logic [7:0]  index, z3, out_keep;
  logic [63:0] out_data;

  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  word_t       exp_q[$];
  logic [63:0] m_d = '0;
  logic [7:0]  m_k = '0;
  int          m_n = 0;
  logic        hold_pending = 1'b0;
  logic [72:0] held = '0;
  logic        s_acc, s_ov, s_last, s_ir;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        p_v = 1'b0;
  logic        p_l = 1'b0;
  logic [31:0] p_x = '0;
  logic [7:0]  p_i = '0;
  logic [7:0]  p_z = '0;

  quant_pack_u8 #(.PACK_N(PN), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready),
    .fx_in(fx_in), .index(index), .z3(z3), .last_in(last_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-half-away-from-zero divide by 2^sh, add zero point, saturate
  function automatic logic [7:0] ref_u8(logic [31:0] x, logic [7:0] idx, logic [7:0] z);
    int     sh;
    longint v, q, s, h;
    sh = (idx > 8'd31) ? 31 : int'(idx);
    v  = longint'($signed(x));
    h  = (sh == 0) ? 0 : (longint'(1) << (sh - 1));
    q  = (v >= 0) ? ((v + h) >>> sh) : -((-v + h) >>> sh);
    s  = q + longint'(z);
    return (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
  endfunction

  function automatic void model_push(logic [7:0] u, logic l);
    word_t w;
    m_d[8*m_n +: 8] = u;
    m_k[m_n] = 1'b1;
    m_n++;
    if (m_n == PN || l) begin
      w.d = m_d;
      w.k = m_k;
      w.l = l;
      exp_q.push_back(w);
      m_d = '0;
      m_k = '0;
      m_n = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_d = '0;
    m_k = '0;
    m_n = 0;
    hold_pending = 1'b0;
    p_v = 1'b0;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, the rising edge then acts on these values
  task automatic cyc(input logic v, input logic [31:0] x, input logic [7:0] idx, input logic [7:0] z,
                     input logic l, input logic ordy);
    word_t e;
    @(negedge clk);
    valid_in = v; fx_in = x; index = idx; z3 = z; last_in = l; out_ready = ordy;
    #1;
    s_acc = v & in_ready; s_ov = out_valid; s_data = out_data; s_keep = out_keep;
    s_last = out_last; s_ir = in_ready;
    if (hold_pending) chk("hold", {out_valid, out_data, out_keep, out_last}, {1'b1, held});
    hold_pending = out_valid & ~ordy;
    held = {out_data, out_keep, out_last};
    if (s_acc) begin
      n_acc++;
      model_push(ref_u8(x, idx, z), l);
    end
    if (out_valid & ordy) begin
      chk("exp_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", out_data, e.d);
        chk("keep", out_keep, e.k);
        chk("last", out_last, e.l);
      end
    end
  endtask

  task automatic wait_ov(input string tag);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
      if (s_ov) break;
    end
    chk(tag, s_ov, 1);
  endtask

  task automatic single(input string tag, input logic [31:0] x, input logic [7:0] idx,
                        input logic [7:0] z, input logic [7:0] e);
    cyc(1'b1, x, idx, z, 1'b1, 1'b1);
    wait_ov({tag, "_v"});
    chk(tag, s_data, {56'd0, e});
    chk({tag, "_k"}, s_keep, 8'h01);
  endtask

  task automatic rnd_step(input logic ordy, input int pv, input int pl);
    if (!p_v && $urandom_range(99) < pv) begin
      p_v = 1'b1;
      p_x = $urandom_range(1) ? $urandom : 32'($urandom_range(800)) - 32'd400;
      p_i = 8'($urandom_range(40));
      p_z = 8'($urandom);
      p_l = ($urandom_range(99) < pl);
    end
    cyc(p_v, p_x, p_i, p_z, p_l, ordy);
    if (s_acc) p_v = 1'b0;
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < 60 && p_v; i++) rnd_step(1'b1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 32'd5, 8'd0, 8'd0, 1'b1, 1'b1);
      if (s_acc) break;
    end
    for (int i = 0; i < 30; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; fx_in = '0; index = '0; z3 = '0; last_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk);
    reset = 1'b1;

    single("zp_add", 32'd100, 8'd0, 8'd5, 8'd105);
    single("rnd_up", 32'd10, 8'd2, 8'd100, 8'd103);
    single("rnd_neg_tie", 32'hFFFF_FFF6, 8'd2, 8'd100, 8'd97);
    single("rnd_dn", 32'd9, 8'd2, 8'd100, 8'd102);
    single("rnd_neg", 32'hFFFF_FFF7, 8'd2, 8'd100, 8'd98);
    single("clamp_hi", 32'd300, 8'd0, 8'd0, 8'd255);
    single("clamp_lo", 32'hFFFF_FFCE, 8'd0, 8'd10, 8'd0);
    single("min_int", 32'h8000_0000, 8'd0, 8'd200, 8'd0);
    single("idx_clamp", 32'h4000_0000, 8'd40, 8'd0, 8'd1);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 32'(i), 8'd0, 8'd0, 1'b0, 1'b1);
      chk("full_acc", s_acc, 1);
    end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("lat_t0", s_ov, 0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("lat_t1", s_ov, 0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("lat_t2", s_ov, 1);
    chk("full_data", s_data, 64'h0807060504030201);
    chk("full_keep", s_keep, 8'hFF);
    chk("full_last", s_last, 0);

    cyc(1'b1, 32'd7, 8'd0, 8'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd8, 8'd0, 8'd0, 1'b0, 1'b1);
    cyc(1'b1, 32'd9, 8'd0, 8'd0, 1'b1, 1'b1);
    wait_ov("part_v");
    chk("part_data", s_data, 64'h0000000000090807);
    chk("part_keep", s_keep, 8'h07);
    chk("part_last", s_last, 1);
    single("after_part", 32'h11, 8'd0, 8'd0, 8'h11);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i + 48), 8'd0, 8'd0, i == 8, 1'b1);
    wait_ov("lastfull_v");
    chk("lastfull_keep", s_keep, 8'hFF);
    chk("lastfull_last", s_last, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
      chk("no_extra", s_ov, 0);
    end

    n_acc = 0;
    for (int i = 0; i < 40; i++) rnd_step(1'b0, 100, 0);
    chk("bp_acc", n_acc, 26);
    chk("bp_ir", s_ir, 0);
    for (int i = 0; i < 40; i++) rnd_step(1'b1, 100, 0);
    flush("bp_drain");

    for (int i = 0; i < 600; i++) rnd_step($urandom_range(99) < 70, 80, 12);
    for (int i = 0; i < 60; i++) rnd_step(1'b0, 100, 100);
    for (int i = 0; i < 400; i++) rnd_step($urandom_range(99) < 50, 90, 30);
    flush("rnd_drain");

    for (int i = 0; i < 20; i++) cyc(1'b1, 32'(i + 64), 8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_ov", s_ov, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ir", in_ready, 1);
    chk("mid_rst_keep", out_keep, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i + 33), 8'd0, 8'd0, 1'b0, 1'b1);
    wait_ov("post_rst_v");
    chk("post_rst_data", s_data, 64'h2827262524232221);
    chk("post_rst_keep", s_keep, 8'hFF);
    chk("post_rst_last", s_last, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("post_rst_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
